// File: rtl/aes_sbox_unit.sv
// aes_sbox_unit: 16-lane AES forward (SubBytes) and inverse (InvSubBytes) S-box built from GF(2^8) inversion.
// Combinational by default; define SBOX_PIPE_EN to register both outputs (1-cycle latency, async clear to 0).
module aes_sbox_unit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] xor_to_sbox,
  output logic [127:0] sbox_to_rows,
  input  logic [127:0] InvRows_to_InvSbox,
  output logic [127:0] InvSBox_out
);

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse for x != 0 and naturally yields 0 for x == 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] fwd_byte(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]} ^ {b[5:0], b[7:6]} ^ {b[6:0], b[7]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_byte(input logic [7:0] x);
    logic [7:0] a;
    a = {x[1:0], x[7:2]} ^ {x[4:0], x[7:5]} ^ {x[6:0], x[7]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  logic [127:0] fwd_comb;
  logic [127:0] inv_comb;

  for (genvar i = 0; i < 16; i++) begin : g_lane
    assign fwd_comb[8*i +: 8] = fwd_byte(xor_to_sbox[8*i +: 8]);
    assign inv_comb[8*i +: 8] = inv_byte(InvRows_to_InvSbox[8*i +: 8]);
  end

`ifdef SBOX_PIPE_EN
  // Reset value is 0, deliberately not S(0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbox_to_rows <= 128'h0;
      InvSBox_out  <= 128'h0;
    end else begin
      sbox_to_rows <= fwd_comb;
      InvSBox_out  <= inv_comb;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk & rst_n;
  assign sbox_to_rows   = fwd_comb;
  assign InvSBox_out    = inv_comb;
`endif

endmodule

// File: tb/tb_aes_sbox_unit.sv
// Self-checking bench for aes_sbox_unit against a brute-force GF(2^8) reference table; handles both build options.
module tb_aes_sbox_unit;

  logic         clk;
  logic         rst_n;
  logic [127:0] fwd_in;
  logic [127:0] fwd_out;
  logic [127:0] inv_drv;
  logic [127:0] inv_in;
  logic [127:0] inv_out;
  logic         chain;

  int checks;
  int failures;

  logic [7:0] s_tbl [256];
  logic [7:0] si_tbl[256];

  assign inv_in = chain ? fwd_out : inv_drv;

  aes_sbox_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .xor_to_sbox       (fwd_in),
    .sbox_to_rows      (fwd_out),
    .InvRows_to_InvSbox(inv_in),
    .InvSBox_out       (inv_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product followed by polynomial long division by 0x11B.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int j = 14; j >= 8; j--)
      if (p[j]) p = p ^ (16'h011b << (j - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic init_model();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      s_tbl[x]  = s;
      si_tbl[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] m_fwd(input logic [127:0] v);
    logic [127:0] r;
    for (int l = 0; l < 16; l++) r[8*l +: 8] = s_tbl[v[8*l +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] m_inv(input logic [127:0] v);
    logic [127:0] r;
    for (int l = 0; l < 16; l++) r[8*l +: 8] = si_tbl[v[8*l +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Wait until outputs reflect inputs driven at the preceding negedge.
  task automatic settle();
`ifdef SBOX_PIPE_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic settle_chain();
`ifdef SBOX_PIPE_EN
    @(posedge clk);
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    chain = 1'b0;
`ifdef SBOX_PIPE_EN
    rst_n   = 1'b0;
    fwd_in  = rand128() | {16{8'h01}};
    inv_drv = rand128() | {16{8'h01}};
    #1;
    checks++;
    if (fwd_out !== 128'h0 || inv_out !== 128'h0) begin
      failures++;
      $display("FAIL reset_hold_async fwd=%h inv=%h required 0", fwd_out, inv_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fwd_out !== 128'h0 || inv_out !== 128'h0) begin
      failures++;
      $display("FAIL reset_hold_clocked fwd=%h inv=%h required 0", fwd_out, inv_out);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    fwd_in  = {16{8'h01}};
    inv_drv = {16{8'hED}};
    @(posedge clk);
    #1;
    checks++;
    if (fwd_out !== {16{8'h7C}} || inv_out !== {16{8'h53}}) begin
      failures++;
      $display("FAIL reset_release fwd=%h inv=%h required %h / %h", fwd_out, inv_out, {16{8'h7C}}, {16{8'h53}});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (fwd_out !== 128'h0 || inv_out !== 128'h0) begin
      failures++;
      $display("FAIL reset_midstream fwd=%h inv=%h required 0", fwd_out, inv_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
`else
    rst_n = 1'b0;
`endif
    @(negedge clk);
    fwd_in  = 128'h0;
    inv_drv = 128'h0;
    settle();
    checks++;
    if (fwd_out !== {16{8'h63}} || inv_out !== {16{8'h52}}) begin
      failures++;
      $display("FAIL all_zero fwd=%h inv=%h required %h / %h", fwd_out, inv_out, {16{8'h63}}, {16{8'h52}});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_anchors();
    logic [7:0] f_in [4] = '{8'h00, 8'h01, 8'h53, 8'hFF};
    logic [7:0] f_exp[4] = '{8'h63, 8'h7C, 8'hED, 8'h16};
    logic [7:0] i_in [4] = '{8'h63, 8'hED, 8'h16, 8'h00};
    logic [7:0] i_exp[4] = '{8'h00, 8'h53, 8'hFF, 8'h52};
    chain = 1'b0;
    @(negedge clk);
    fwd_in  = {120'h0, 8'h53};
    inv_drv = {8'h16, 120'h0};
    settle();
    checks++;
    if (fwd_out !== {{15{8'h63}}, 8'hED}) begin
      failures++;
      $display("FAIL anchor_fwd_lane0 got=%h required=%h", fwd_out, {{15{8'h63}}, 8'hED});
    end
    checks++;
    if (inv_out !== {8'hFF, {15{8'h52}}}) begin
      failures++;
      $display("FAIL anchor_inv_lane15 got=%h required=%h", inv_out, {8'hFF, {15{8'h52}}});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fwd_in  = {16{f_in[k]}};
      inv_drv = {16{i_in[k]}};
      settle();
      checks++;
      if (fwd_out !== {16{f_exp[k]}} || inv_out !== {16{i_exp[k]}}) begin
        failures++;
        $display("FAIL anchor_%0d fwd=%h inv=%h required %h / %h", k, fwd_out, inv_out, {16{f_exp[k]}}, {16{i_exp[k]}});
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] a;
    logic [127:0] b;
    chain = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      a = rand128();
      b = rand128();
      fwd_in  = a;
      inv_drv = b;
      settle();
      checks++;
      if (fwd_out !== m_fwd(a)) begin
        failures++;
        $display("FAIL random_fwd in=%h got=%h required=%h", a, fwd_out, m_fwd(a));
      end
      checks++;
      if (inv_out !== m_inv(b)) begin
        failures++;
        $display("FAIL random_inv in=%h got=%h required=%h", b, inv_out, m_inv(b));
      end
    end
  endtask

  task automatic test_full_table();
    chain = 1'b0;
    for (int x = 0; x < 256; x++) begin
      @(negedge clk);
      fwd_in  = {16{8'(x)}};
      inv_drv = {16{8'(x)}};
      settle();
      checks++;
      if (fwd_out !== {16{s_tbl[x]}} || inv_out !== {16{si_tbl[x]}}) begin
        failures++;
        $display("FAIL full_table x=%h fwd=%h inv=%h required %h / %h", x[7:0], fwd_out, inv_out, {16{s_tbl[x]}}, {16{si_tbl[x]}});
      end
    end
  endtask

  task automatic test_walking_roundtrip();
    logic [127:0] v;
    bit bad;
    bad   = 1'b0;
    chain = 1'b1;
    for (int l = 0; l < 16 && !bad; l++) begin
      for (int x = 0; x < 256 && !bad; x++) begin
        @(negedge clk);
        v = 128'h0;
        v[8*l +: 8] = 8'(x);
        fwd_in = v;
        settle_chain();
        checks++;
        if (inv_out !== v) begin
          failures++;
          bad = 1'b1;
          $display("FAIL walking_roundtrip lane=%0d in=%h got=%h", l, v, inv_out);
        end
      end
    end
    chain = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] hist[$];
    logic [127:0] v;
    chain = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
`ifdef SBOX_PIPE_EN
      if (i >= 2) begin
        checks++;
        if (inv_out !== hist[i-2]) begin
          failures++;
          $display("FAIL b2b_roundtrip step=%0d got=%h required=%h", i, inv_out, hist[i-2]);
        end
      end
      if (i >= 1) begin
        checks++;
        if (fwd_out !== m_fwd(hist[i-1])) begin
          failures++;
          $display("FAIL b2b_fwd step=%0d got=%h required=%h", i, fwd_out, m_fwd(hist[i-1]));
        end
      end
`endif
      v = rand128();
      fwd_in = v;
      hist.push_back(v);
`ifndef SBOX_PIPE_EN
      #1;
      checks++;
      if (inv_out !== v) begin
        failures++;
        $display("FAIL b2b_roundtrip step=%0d got=%h required=%h", i, inv_out, v);
      end
`endif
    end
    chain = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    chain    = 1'b0;
    fwd_in   = 128'h0;
    inv_drv  = 128'h0;
    init_model();
    test_reset();
    test_anchors();
    test_random();
    test_full_table();
    test_walking_roundtrip();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
